spi_p2s_master: RTL

Parallel-to-serial SPI master transmitter. It sits directly upstream of the serial-to-parallel shift-register receiver (sr_s2p) in the SPI lab datapath. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first in SPI mode 0. It generates the serial clock, the active-high frame enable and the serial data line that feed the receiver's clk/enable/data_in inputs.

---
 rtl/spi_p2s_master.sv | 119 +++++++++++
 1 files changed

// File: rtl/spi_p2s_master.sv
// spi_p2s_master: parallel-to-serial SPI mode-0 transmitter.
// Takes one word over a valid/ready handshake and sends it MSB-first on
// mosi, framed by an active-high spi_enable, with sclk idling low.
// A frame spans CLK_DIV*(2*DATA_WIDTH+2) clocks: CLK_DIV clocks of lead-in,
// DATA_WIDTH full sclk periods, and CLK_DIV clocks of trailing enable.
module spi_p2s_master #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  spi_enable,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(DATA_WIDTH - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DIV_W-1:0]      div_cnt;
    logic                  tail;     // last bit has had its falling edge
    logic                  div_end;

    assign div_end = (div_cnt == DIV_LAST);

    // Frame sequencer: handshake, half-period divider, shifting and framing.
    // NOTE: all state updates use non-blocking assignments so every register
    // sees the pre-edge values of the others; reset is asynchronous and
    // active-low, and it clears the whole datapath including the shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            tail       <= 1'b0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            spi_enable <= 1'b0;
            done       <= 1'b0;
            tx_ready   <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (tx_valid) begin
                        shreg      <= tx_data;
                        bit_cnt    <= CNT_MSB;
                        tail       <= 1'b0;
                        mosi       <= tx_data[DATA_WIDTH-1];
                        spi_enable <= 1'b1;
                        tx_ready   <= 1'b0;
                        state      <= LEAD;
                    end
                end
                LEAD: begin
                    // Data setup before the first rising edge.
                    if (div_end) begin
                        div_cnt <= '0;
                        sclk    <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!div_end) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (sclk) begin
                            // Falling edge: present the next bit while sclk is low.
                            sclk <= 1'b0;
                            if (bit_cnt != '0) begin
                                shreg   <= shreg << 1;
                                mosi    <= shreg[DATA_WIDTH-2];
                                bit_cnt <= bit_cnt - 1'b1;
                            end else begin
                                tail <= 1'b1;
                            end
                        end else if (tail) begin
                            // Last low half-period done; frame holds whole sclk periods.
                            state <= TRAIL;
                        end else begin
                            sclk <= 1'b1;
                        end
                    end
                end
                TRAIL: begin
                    if (div_end) begin
                        div_cnt    <= '0;
                        tail       <= 1'b0;
                        spi_enable <= 1'b0;
                        done       <= 1'b1;
                        tx_ready   <= 1'b1;
                        mosi       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
